// File: rtl/corelet_seq_if.sv
// Handshake and bus bundle between the host/corelet environment and the layer sequencer.
// master drives the request, config and OFIFO status; slave is the sequencer.
interface corelet_seq_if #(
  parameter int XADDR_BW = 11,
  parameter int PADDR_BW = 11
);
  logic                start;
  logic                cfg_mode;
  logic [3:0]          cfg_npass;
  logic [6:0]          cfg_nact;
  logic                ofifo_valid;
  logic [34:0]         inst;
  logic                xmem_rd;
  logic [XADDR_BW-1:0] xmem_addr;
  logic                pmem_wr;
  logic [PADDR_BW-1:0] pmem_addr;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, cfg_mode, cfg_npass, cfg_nact, ofifo_valid,
    input  inst, xmem_rd, xmem_addr, pmem_wr, pmem_addr, busy, done, err
  );

  modport slave (
    input  start, cfg_mode, cfg_npass, cfg_nact, ofifo_valid,
    output inst, xmem_rd, xmem_addr, pmem_wr, pmem_addr, busy, done, err
  );
endinterface

// File: rtl/corelet_seq.sv
// Layer-op sequencer: per pass runs weight fill, kernel load, flush, activation fill, execute, OFIFO drain.
// Every output is registered from the current state/counters; DRAIN stalls indefinitely on ofifo_valid.
module corelet_seq #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int L0_DEPTH = 64,
  parameter int XADDR_BW = 11,
  parameter int PADDR_BW = 11,
  parameter int W_BASE   = 0,
  parameter int A_BASE   = 1024,
  parameter int P_BASE   = 0
) (
  input logic          clk,
  input logic          reset,
  corelet_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFILL  = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_WFLUSH = 3'd3;
  localparam logic [2:0] S_AFILL  = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;
  localparam int         CNT_BW   = 8;

  logic [2:0]          state_q, state_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic [3:0]          k_q, k_d, npass_q, npass_d;
  logic [6:0]          nact_q, nact_d;
  logic                mode_q, mode_d;
  logic [34:0]         inst_q, inst_d;
  logic                xrd_q, xrd_d;
  logic [XADDR_BW-1:0] xaddr_q, xaddr_d;
  logic                pwr_q, pwr_d;
  logic [PADDR_BW-1:0] paddr_q, paddr_d, pstage_q, pstage_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_BW-1:0]   nact_w;
  logic                cfg_bad;

  assign nact_w  = CNT_BW'(nact_q);
  assign cfg_bad = (bus.cfg_npass == 4'd0) || (bus.cfg_nact == 7'd0) ||
                   (CNT_BW'(bus.cfg_nact) > CNT_BW'(L0_DEPTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    k_d      = k_q;
    npass_d  = npass_q;
    nact_d   = nact_q;
    mode_d   = mode_q;
    inst_d   = '0;
    xrd_d    = 1'b0;
    xaddr_d  = '0;
    pstage_d = pstage_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WFILL;
            k_d     = '0;
            npass_d = bus.cfg_npass;
            nact_d  = bus.cfg_nact;
            mode_d  = bus.cfg_mode;
          end
        end
      end
      // L0 write trails the xmem read by one cycle, hence the extra fill cycle.
      S_WFILL: begin
        inst_d[2] = (cnt_q != '0);
        if (cnt_q < CNT_BW'(COL)) begin
          xrd_d   = 1'b1;
          xaddr_d = XADDR_BW'(W_BASE) + XADDR_BW'(k_q) * XADDR_BW'(COL) + XADDR_BW'(cnt_q);
        end else begin
          state_d = S_WLOAD;
          cnt_d   = '0;
        end
      end
      S_WLOAD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
        if (cnt_q == CNT_BW'(COL - 1)) begin
          state_d = S_WFLUSH;
          cnt_d   = '0;
        end
      end
      S_WFLUSH: begin
        if (cnt_q == CNT_BW'(ROW + COL - 1)) begin
          state_d = S_AFILL;
          cnt_d   = '0;
        end
      end
      S_AFILL: begin
        inst_d[2] = (cnt_q != '0);
        if (cnt_q < nact_w) begin
          xrd_d   = 1'b1;
          xaddr_d = XADDR_BW'(A_BASE) + XADDR_BW'(cnt_q);
        end else begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
        if (cnt_q == nact_w - 1'b1) begin
          state_d = S_EXEC + 3'd1;
          cnt_d   = '0;
        end
      end
      // Leave only once the last ofifo_rd has turned into its pmem write.
      S_DRAIN: begin
        cnt_d = cnt_q;
        if (cnt_q == nact_w) begin
          cnt_d = '0;
          if (k_q + 4'd1 == npass_q) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_WFILL;
          end
        end else if (bus.ofifo_valid) begin
          inst_d[6] = 1'b1;
          pstage_d  = PADDR_BW'(P_BASE) + PADDR_BW'(k_q) * PADDR_BW'(nact_q) + PADDR_BW'(cnt_q);
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d     = (state_q != S_IDLE) || (state_d != S_IDLE);
    inst_d[34] = busy_d & mode_d;
    pwr_d      = inst_q[6];
    paddr_d    = inst_q[6] ? pstage_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      npass_q  <= '0;
      nact_q   <= '0;
      mode_q   <= 1'b0;
      inst_q   <= '0;
      xrd_q    <= 1'b0;
      xaddr_q  <= '0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pstage_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      npass_q  <= npass_d;
      nact_q   <= nact_d;
      mode_q   <= mode_d;
      inst_q   <= inst_d;
      xrd_q    <= xrd_d;
      xaddr_q  <= xaddr_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pstage_q <= pstage_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.inst      = inst_q;
  assign bus.xmem_rd   = xrd_q;
  assign bus.xmem_addr = xaddr_q;
  assign bus.pmem_wr   = pwr_q;
  assign bus.pmem_addr = paddr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_corelet_seq.sv
// Bench for corelet_seq: an event-list reference model feeds a scoreboard queue that a negedge monitor drains.
// Directed scenarios plus randomized layer ops; per-cycle timing relations are checked alongside the event stream.
module tb_corelet_seq;
  localparam int ROWS = 8, COLS = 8, ABASE = 1024, L0D = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corelet_seq_if #(.XADDR_BW(11), .PADDR_BW(11)) bus();
  corelet_seq dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {byte kind; int val;} tok_t;
  tok_t exp_q[$];
  tok_t cyc_q[$];
  bit   pat_q[$];

  int  n_chk = 0, n_fail = 0;
  int  done_cnt = 0, e_cnt = 0, o_cnt = 0, idle_cnt = 0, cur_nact = 1;
  bit  cur_mode = 0, start_ok = 0, exp_busy = 0, ofv_hold = 0;
  bit  prev_xrd = 0, prev_i6 = 0, prev_ofv = 0, prev_drain = 0, after_k = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_tok(input byte kind, input int val);
    tok_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %c %0d, nothing expected (t=%0t)", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL event: got %c %0d, required %c %0d (t=%0t)", kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  task automatic push_tok(input byte kind, input int val);
    tok_t t;
    t.kind = kind; t.val = val;
    exp_q.push_back(t);
  endtask

  // Reference: the ordered list of observable events of one complete layer op.
  task automatic model_op(input int np, input int na);
    for (int k = 0; k < np; k++) begin
      push_tok("R", k * COLS);
      for (int i = 1; i < COLS; i++) begin push_tok("W", 0); push_tok("R", k * COLS + i); end
      push_tok("W", 0);
      for (int i = 0; i < COLS; i++) push_tok("K", 0);
      push_tok("F", ROWS + COLS);
      push_tok("R", ABASE);
      for (int i = 1; i < na; i++) begin push_tok("W", 0); push_tok("R", ABASE + i); end
      push_tok("W", 0);
      for (int i = 0; i < na; i++) push_tok("E", 0);
      for (int j = 0; j < na; j++) begin push_tok("O", 0); push_tok("P", (k * na + j) % 2048); end
    end
    push_tok("D", 0);
  endtask

  function automatic tok_t mk(input byte kind, input int val);
    tok_t t;
    t.kind = kind; t.val = val;
    return t;
  endfunction

  always @(posedge clk) begin
    #1;
    if (ofv_hold)               bus.ofifo_valid = 1'b0;
    else if (pat_q.size() > 0)  bus.ofifo_valid = pat_q.pop_front();
    else                        bus.ofifo_valid = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_xrd = 0; prev_i6 = 0; prev_ofv = 0; prev_drain = 0; after_k = 0;
      idle_cnt = 0; e_cnt = 0; o_cnt = 0; exp_busy = 0;
    end else begin
      bit has_k;
      chk("busy", bus.busy, exp_busy);
      chk("inst_unused_bits", bus.inst & ~35'h4_0000_004F, 0);
      chk("inst_mode", bus.inst[34], bus.busy ? cur_mode : 1'b0);
      chk("l0_wr_lag", bus.inst[2], prev_xrd);
      chk("pmem_wr_lag", bus.pmem_wr, prev_i6);
      if (prev_drain) chk("ofifo_rd_mirror", bus.inst[6], prev_ofv);
      cyc_q.delete();
      if (bus.pmem_wr) cyc_q.push_back(mk("P", int'(bus.pmem_addr)));
      if (bus.inst[6]) cyc_q.push_back(mk("O", 0));
      if (bus.inst[2]) cyc_q.push_back(mk("W", 0));
      if (bus.xmem_rd) cyc_q.push_back(mk("R", int'(bus.xmem_addr)));
      if (bus.inst[3] | bus.inst[1] | bus.inst[0]) begin
        if (bus.inst[3:0] == 4'b1001)      cyc_q.push_back(mk("K", 0));
        else if (bus.inst[3:0] == 4'b1010) cyc_q.push_back(mk("E", 0));
        else                               cyc_q.push_back(mk("?", int'(bus.inst[3:0])));
      end
      if (bus.done) cyc_q.push_back(mk("D", 0));
      if (bus.err)  cyc_q.push_back(mk("X", 0));
      has_k = 0;
      foreach (cyc_q[i]) if (cyc_q[i].kind == "K") has_k = 1;
      if (cyc_q.size() > 0 && after_k && !has_k) begin chk_tok("F", idle_cnt); after_k = 0; end
      if (has_k) begin after_k = 1; idle_cnt = 0; end
      else if (cyc_q.size() == 0 && after_k) idle_cnt++;
      foreach (cyc_q[i]) begin
        chk_tok(cyc_q[i].kind, cyc_q[i].val);
        if (cyc_q[i].kind == "E") e_cnt++;
        if (cyc_q[i].kind == "D") done_cnt++;
        if (cyc_q[i].kind == "O") begin
          o_cnt++;
          if (o_cnt >= cur_nact) begin o_cnt = 0; e_cnt = 0; end
        end
      end
      prev_drain = (e_cnt == cur_nact) && (o_cnt < cur_nact);
      prev_xrd = bus.xmem_rd;
      prev_i6  = bus.inst[6];
      prev_ofv = bus.ofifo_valid;
      if (bus.done) exp_busy = 0;
      if (bus.start && start_ok) exp_busy = 1;
    end
  end

  task automatic issue_start(input bit mode, input int np, input int na, input bit idle);
    bit ok;
    @(posedge clk); #1;
    bus.cfg_mode = mode; bus.cfg_npass = np[3:0]; bus.cfg_nact = na[6:0]; bus.start = 1'b1;
    ok = idle && np != 0 && na != 0 && na <= L0D;
    start_ok = ok;
    if (ok) begin cur_mode = mode; cur_nact = na; model_op(np, na); end
    else if (idle) push_tok("X", 0);
    @(posedge clk); #1;
    bus.start = 1'b0; start_ok = 0;
    bus.cfg_mode = 1'($urandom); bus.cfg_npass = 4'($urandom); bus.cfg_nact = 7'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    n_chk++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, required one", name, budget);
    end
    repeat (4) @(posedge clk);
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_leftover_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_e(input string name);
    int n;
    n = 0;
    while (e_cnt == 0 && n < 3000) begin @(posedge clk); n++; end
    chk({name, "_reached_exec"}, e_cnt > 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_npass = 4'd0; bus.cfg_nact = 7'd0;
    #2;
    chk("rst_inst", bus.inst, 0);
    chk("rst_xmem_rd", bus.xmem_rd, 0);
    chk("rst_pmem_wr", bus.pmem_wr, 0);
    chk("rst_busy_done_err", {bus.busy, bus.done, bus.err}, 0);
    chk("rst_addrs", {bus.xmem_addr, bus.pmem_addr}, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    issue_start(0, 1, 4, 1);
    wait_done("single_pass", 2000);

    issue_start(0, 3, 2, 1);
    wait_done("three_pass", 4000);

    issue_start(0, 1, 0, 1);
    repeat (4) @(posedge clk);
    issue_start(0, 1, 65, 1);
    repeat (4) @(posedge clk);
    issue_start(0, 0, 4, 1);
    repeat (6) @(posedge clk);
    chk("reject_leftover_events", exp_q.size(), 0);
    exp_q.delete();

    ofv_hold = 1;
    issue_start(0, 1, 4, 1);
    wait_e("ofifo_pattern");
    repeat (2) @(posedge clk);
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ofv_hold = 0;
    wait_done("ofifo_pattern", 2000);

    issue_start(1, 2, 5, 1);
    wait_e("os_mode");
    issue_start(0, 1, 3, 0);
    wait_done("os_mode", 4000);

    issue_start(0, 2, 8, 1);
    begin
      int n;
      n = 0;
      while (o_cnt == 0 && n < 3000) begin @(posedge clk); n++; end
      chk("reached_drain", o_cnt > 0, 1);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_inst", bus.inst, 0);
    chk("midrst_xmem_rd", bus.xmem_rd, 0);
    chk("midrst_pmem_wr", bus.pmem_wr, 0);
    chk("midrst_busy", bus.busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    issue_start(0, 1, 4, 1);
    wait_done("after_reset", 2000);

    for (int r = 0; r < 6; r++) begin
      issue_start(1'($urandom), $urandom_range(1, 3), $urandom_range(1, L0D), 1);
      wait_done("random_op", 6000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
